// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: frames set-2 scan codes, decodes E0/F0 prefixes and tracks one key as a level.
// Optional build macro PS2_PARITY_CHECK_EN enables odd-parity checking of each frame.
module ps2_key_receiver #(
  parameter logic [7:0]  KEY_CODE       = 8'h29,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       iReset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       keyPress,
  output logic [7:0] scanCode,
  output logic       scanBreak,
  output logic       scanExt,
  output logic       scanValid,
  output logic       frameErr
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          clk_prev_q, clk_prev_d;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_rdy_q, byte_rdy_d;
  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic          key_q, key_d;
  logic [7:0]    code_q, code_d;
  logic          break_q, break_d;
  logic          sext_q, sext_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_q, par_d;
`endif

  logic fall;
  logic din;
  logic frame_ok;

  always_comb begin
    clk_sync_d = {clk_sync_q[0], PS2_CLK};
    dat_sync_d = {dat_sync_q[0], PS2_DAT};
    clk_prev_d = clk_sync_q[1];
    fall       = clk_prev_q & ~clk_sync_q[1];
    din        = dat_sync_q[1];

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    byte_rdy_d = 1'b0;
    err_d      = 1'b0;
    frame_ok   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d      = par_q;
`endif

    // An edge in the same cycle as expiry wins, since the counter only trips when !fall.
    if (state_q == IDLE || fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
      to_cnt_d = '0;
      state_d  = IDLE;
      err_d    = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!din) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = din;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
`ifdef PS2_PARITY_CHECK_EN
          frame_ok = din & (^{shift_q, par_q});
`else
          frame_ok = din;
`endif
          if (frame_ok) begin
            byte_rdy_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ext_d   = ext_q;
    brk_d   = brk_q;
    key_d   = key_q;
    code_d  = code_q;
    break_d = break_q;
    sext_d  = sext_q;
    valid_d = 1'b0;
    if (byte_rdy_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        code_d  = byte_q;
        break_d = brk_q;
        sext_d  = ext_q;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
        if (!ext_q && byte_q == KEY_CODE) key_d = ~brk_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (iReset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      to_cnt_q   <= '0;
      byte_q     <= '0;
      byte_rdy_q <= 1'b0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_q      <= 1'b0;
      code_q     <= '0;
      break_q    <= 1'b0;
      sext_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      to_cnt_q   <= to_cnt_d;
      byte_q     <= byte_d;
      byte_rdy_q <= byte_rdy_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      key_q      <= key_d;
      code_q     <= code_d;
      break_q    <= break_d;
      sext_q     <= sext_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign keyPress  = key_q;
  assign scanCode  = code_q;
  assign scanBreak = break_q;
  assign scanExt   = sext_q;
  assign scanValid = valid_q;
  assign frameErr  = err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: drives PS/2 frames on the pins and checks decoded events.
module tb_ps2_key_receiver;

  logic       clk = 1'b0;
  logic       iReset;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       keyPress;
  logic [7:0] scanCode;
  logic       scanBreak;
  logic       scanExt;
  logic       scanValid;
  logic       frameErr;

  ps2_key_receiver #(.KEY_CODE(8'h29), .TIMEOUT_CYCLES(50000)) dut (
    .clk      (clk),
    .iReset   (iReset),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat),
    .keyPress (keyPress),
    .scanCode (scanCode),
    .scanBreak(scanBreak),
    .scanExt  (scanExt),
    .scanValid(scanValid),
    .frameErr (frameErr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       kp;
    logic       kp_prev;
  } ev_t;

  ev_t         evq[$];
  int unsigned err_cnt     = 0;
  int unsigned long_pulses = 0;
  logic        kp_last     = 1'b0;
  logic        sv_last     = 1'b0;
  logic        fe_last     = 1'b0;
  int unsigned n_vec       = 0;
  int unsigned n_err       = 0;

  // Event recorder, sampled on the inactive edge.
  always @(negedge clk) begin
    if (scanValid) evq.push_back('{scanCode, scanBreak, scanExt, keyPress, kp_last});
    if (frameErr) err_cnt <= err_cnt + 1;
    if ((scanValid && sv_last) || (frameErr && fe_last)) long_pulses <= long_pulses + 1;
    kp_last <= keyPress;
    sv_last <= scanValid;
    fe_last <= frameErr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(data[i]);
    ps2_bit(par);
    ps2_bit(stop);
    ps2_dat = 1'b1;
    repeat (12) @(posedge clk);
  endtask

  task automatic send_ok(input logic [7:0] data);
    send_frame(data, ~^data, 1'b1);
  endtask

  task automatic expect_scan(input string tag, input logic [7:0] code, input logic brk,
                             input logic ext, input logic kp, input logic kp_prev);
    ev_t e;
    if (evq.size() == 0) begin
      chk({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      e = evq.pop_front();
      chk({tag, "_code"}, {24'd0, e.code}, {24'd0, code});
      chk({tag, "_brk"}, {31'd0, e.brk}, {31'd0, brk});
      chk({tag, "_ext"}, {31'd0, e.ext}, {31'd0, ext});
      chk({tag, "_kp"}, {31'd0, e.kp}, {31'd0, kp});
      chk({tag, "_kp_prev"}, {31'd0, e.kp_prev}, {31'd0, kp_prev});
    end
  endtask

  task automatic expect_quiet(input string tag);
    chk({tag, "_no_scan"}, evq.size(), 32'd0);
    evq.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_outs"}, {24'd0, keyPress, scanCode, scanBreak, scanExt, scanValid, frameErr},
        32'd0);
  endtask

  int unsigned e0;
  int unsigned w;

  initial begin
    iReset  = 1'b1;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    iReset = 1'b0;
    repeat (10) @(posedge clk);

    // Single make of the tracked key.
    send_ok(8'h29);
    expect_scan("make29", 8'h29, 1'b0, 1'b0, 1'b1, 1'b0);

    // Typematic repeats, then release.
    for (int i = 0; i < 3; i++) begin
      send_ok(8'h29);
      expect_scan("repeat29", 8'h29, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    send_ok(8'hF0);
    expect_quiet("f0_prefix");
    send_ok(8'h29);
    expect_scan("break29", 8'h29, 1'b1, 1'b0, 1'b0, 1'b1);

    // Extended codes equal to the key code must not touch keyPress.
    send_ok(8'hE0);
    send_ok(8'h29);
    expect_scan("ext_make", 8'h29, 1'b0, 1'b1, 1'b0, 1'b0);
    send_ok(8'hE0);
    send_ok(8'hF0);
    send_ok(8'h29);
    expect_scan("ext_break", 8'h29, 1'b1, 1'b1, 1'b0, 1'b0);

    // 1C has three ones: parity 0 is odd-correct, parity 1 is wrong.
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    expect_scan("par_good_1c", 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    expect_quiet("par_bad_1c");
    chk("par_bad_err", err_cnt - e0, 32'd1);
`else
    expect_scan("par_ignored_1c", 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_ignored_err", err_cnt - e0, 32'd0);
`endif

    // Bad stop bit discards the frame and keeps scan outputs.
    e0 = err_cnt;
    send_frame(8'h29, 1'b1, 1'b0);
    expect_quiet("bad_stop");
    chk("bad_stop_err", err_cnt - e0, 32'd1);
    chk("bad_stop_hold", {23'd0, keyPress, scanCode}, {23'd0, 1'b0, 8'h1C});

    // Partial frame followed by a silent bus must time out.
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_dat = 1'b1;
    w = 0;
    while (err_cnt == e0 && w < 60000) begin
      @(posedge clk);
      w++;
    end
    chk("timeout_err", err_cnt - e0, 32'd1);
    chk("timeout_window", {31'd0, (w >= 49980 && w <= 50010)}, 32'd1);
    expect_quiet("timeout");
    repeat (5) @(posedge clk);
    send_ok(8'h29);
    expect_scan("after_timeout", 8'h29, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a frame abandons it silently.
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    iReset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("mid_reset");
    ps2_dat = 1'b1;
    iReset  = 1'b0;
    repeat (30) @(posedge clk);
    chk("mid_reset_err", err_cnt - e0, 32'd0);
    expect_quiet("mid_reset");
    send_ok(8'hF0);
    send_ok(8'h29);
    expect_scan("post_reset_break", 8'h29, 1'b1, 1'b0, 1'b0, 1'b0);

    chk("pulse_width", long_pulses, 32'd0);
    expect_quiet("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
